// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_if
//  Description : Operand-read / write-back bundle between the core and regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_if #(
    parameter int XLEN = 32
);
    logic [31:0]     bus;
    logic [XLEN-1:0] rs1_out;
    logic [XLEN-1:0] rs2_out;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ready;
    logic            wb_lost;

    // Core side: supplies the instruction word and the write-back request.
    modport master (
        output bus,
        output wb_valid,
        output wb_rd,
        output wb_data,
        input  rs1_out,
        input  rs2_out,
        input  ready,
        input  wb_lost
    );

    // Register-file side.
    modport slave (
        input  bus,
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        output rs1_out,
        output rs2_out,
        output ready,
        output wb_lost
    );
endinterface
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : RV32I/RV32E integer register file with post-reset clear
//                sequencer. Define REGFILE_BYPASS_EN for write-to-read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic      CLK,
    input  logic      reset,
    regfile_if.slave  rf
);

    localparam int         IDX_W      = $clog2(NREGS);
    localparam logic [5:0] c_NREGS    = 6'(NREGS);
    localparam logic [4:0] c_LAST_IDX = 5'(NREGS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_clr_idx;
    logic [4:0]      w_clr_idx_nxt;
    logic            r_wb_lost;
    logic            w_wb_lost_nxt;

    // No reset on the array so it maps onto distributed RAM; the sequencer zeroes it.
    logic [XLEN-1:0] r_mem [NREGS];

    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_addr;
    logic [XLEN-1:0]  w_mem_wdata;

    logic             w_wb_legal;
    logic [4:0]       w_rs1_idx;
    logic [4:0]       w_rs2_idx;
    logic             w_unused;

    assign w_rs1_idx  = rf.bus[19:15];
    assign w_rs2_idx  = rf.bus[24:20];
    assign w_unused   = ^{rf.bus[31:25], rf.bus[14:0]};

    assign w_wb_legal = rf.wb_valid && (rf.wb_rd != 5'd0) && ({1'b0, rf.wb_rd} < c_NREGS);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= 5'd1;
            r_wb_lost <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_wb_lost <= w_wb_lost_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and array write port selection
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_wb_lost_nxt = r_wb_lost;
        w_mem_we      = 1'b0;
        w_mem_addr    = r_clr_idx[IDX_W-1:0];
        w_mem_wdata   = '0;

        case (r_state)
            ST_CLEAR: begin
                // The clear write owns the port; any write-back is dropped and flagged.
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_idx[IDX_W-1:0];
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + 5'd1;
                end
                if (rf.wb_valid) begin
                    w_wb_lost_nxt = 1'b1;
                end
            end

            ST_READY: begin
                if (w_wb_legal) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = rf.wb_rd[IDX_W-1:0];
                    w_mem_wdata = rf.wb_data;
                end
            end

            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------------
    function automatic logic [XLEN-1:0] f_read(input logic [4:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (r_state == ST_READY) begin
`ifdef REGFILE_BYPASS_EN
            if (w_wb_legal && (rf.wb_rd == idx)) begin
                v = rf.wb_data;
            end else if ((idx != 5'd0) && ({1'b0, idx} < c_NREGS)) begin
                v = r_mem[idx[IDX_W-1:0]];
            end
`else
            if ((idx != 5'd0) && ({1'b0, idx} < c_NREGS)) begin
                v = r_mem[idx[IDX_W-1:0]];
            end
`endif
        end
        return v;
    endfunction

    assign rf.rs1_out = f_read(w_rs1_idx);
    assign rf.rs2_out = f_read(w_rs2_idx);
    assign rf.ready   = (r_state == ST_READY);
    assign rf.wb_lost = r_wb_lost;

endmodule
`default_nettype wire

// File: doc/regfile.md
# regfile

Architectural integer register file for the one-stage RV32 core. It sits directly upstream of the ALU and decodes the rs1/rs2 fields from the same instruction word the ALU sees on `bus`. It drives the ALU operands and accepts the ALU/load result back as the write-back port. A post-reset clear sequencer zeroes the storage, because the array is inferred as distributed RAM without reset, and holds the core off until the clear is done.

## Interface
- `XLEN`, 32, data width of each register and of all data ports.
- `NREGS`, 32, number of architectural registers; legal values are 32 (RV32I) and 16 (RV32E).

- `CLK`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bus`  in  32  current instruction word; rs1 = `bus[19:15]`, rs2 = `bus[24:20]`.
- `rs1_out`  out  XLEN  operand A to the ALU `rs1_in`.
- `rs2_out`  out  XLEN  operand B to the ALU `rs2_in`.
- `wb_valid`  in  1  write-back request this cycle.
- `wb_rd`  in  5  write-back destination index.
- `wb_data`  in  XLEN  write-back value (ALU `alu_out` or load data).
- `ready`  out  1  high when the clear is finished and the file is accepting writes.
- `wb_lost`  out  1  sticky flag, set when a write-back was dropped during the clear.

## Operation
- Storage is an `NREGS` x `XLEN` array. Index 0 is hardwired to zero: it always reads 0 and writes to it are discarded.
- Reads are combinational from `bus`.
  - Index 0, or an index >= `NREGS`, reads 0.
  - While `state == CLEAR`, both outputs read 0 regardless of index.
- The FSM has two states, CLEAR and READY.
  - CLEAR:
    - Each rising edge writes 0 to entry `clr_idx`, then `clr_idx++`.
    - When `clr_idx == NREGS-1`, that final zero write happens and the next state is READY.
    - `ready` = 0.
  - READY:
    - If `wb_valid && wb_rd != 0 && wb_rd < NREGS`, entry `wb_rd` is written with `wb_data` on the rising edge.
    - `ready` = 1. The FSM stays in READY until reset.
- Write-back during CLEAR: the write is ignored, `wb_lost` is set to 1, and it holds until reset. The clear write always wins.
- `clr_idx` is 5 bits, starts at 1, and never wraps: the FSM leaves CLEAR at `NREGS-1`.

## Timing
- Reset asserted, immediately and asynchronously:
  - `state` = CLEAR, `clr_idx` = 1, `ready` = 0, `wb_lost` = 0.
  - `rs1_out` = `rs2_out` = 0.
- Clear latency:
  - After reset deasserts, the 1st rising edge clears x1 and edge k clears x(k).
  - `ready` rises after edge `NREGS-1`: edge 31 for the default, edge 15 for RV32E.
- Reset asserted mid-clear or while READY restarts the clear from x1 and clears `wb_lost`.
- Write latency:
  - A write on edge N is visible on `rs*_out` in the cycle after edge N with no bypass.
  - With bypass (see Configuration), it is visible combinationally in the same cycle as `wb_valid`.
- Same rd read on both ports: both outputs return the identical value, including the bypass case.
- `wb_valid` with `wb_rd == 0`: nothing changes and outputs stay 0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Enables write-to-read forwarding.
  - If `state == READY && wb_valid && wb_rd != 0 && wb_rd == rs1` (or `rs2`), the corresponding output takes `wb_data` in the same cycle.
  - The array write still occurs on the edge.
- `REGFILE_BYPASS_EN` undefined:
  - No forwarding. The output shows the pre-write array value until the edge.

## Test plan
- Reset release, `bus` selecting rs1=x5/rs2=x31: `ready` = 0 and outputs 0 for edges 1–30; `ready` = 1 after edge 31; both outputs read 0.
- READY, write x3 = 0xDEADBEEF, then `bus` rs1=x3/rs2=x0: `rs1_out` = 0xDEADBEEF, `rs2_out` = 0.
- READY, `wb_valid` with rd=x0 and data 0x12345678, then read x0: reads 0 and no other entry changes.
- Mid-clear (edge 10), `wb_valid` rd=x7 data 0xAA: `wb_lost` = 1; after `ready`, x7 reads 0; pulsing `reset` clears `wb_lost` and restarts the 31-cycle clear.
- READY with x9 = 0x1, same cycle `wb_valid` rd=x9 data 0x2 and rs1=rs2=x9:
  - With `REGFILE_BYPASS_EN`, both outputs = 0x2 in that cycle.
  - Without it, both = 0x1, then 0x2 after the edge.
- `NREGS` = 16: `ready` after edge 15; a write to x20 is ignored and x20 reads 0.
